// File: rtl/snow64_ext_mem_bridge_pkg.sv
// Shared types for the CPU-to-external-memory line bridge: CPU port field types,
// bridge FSM states and the narrow external bus bundles.
package snow64_ext_mem_bridge_pkg;

    localparam int LAR_DATA_WIDTH_DFLT = 256;
    localparam int CPU_ADDR_WIDTH_DFLT = 64;
    localparam int BEAT_WIDTH_DFLT     = 64;
    localparam int NUM_BEATS_DFLT      = LAR_DATA_WIDTH_DFLT / BEAT_WIDTH_DFLT;
    localparam int LINE_OFFSET_BITS    = 5;

    typedef enum logic {
        ExtDataAccRead  = 1'b0,
        ExtDataAccWrite = 1'b1
    } ext_data_access_type_e;

    typedef logic [CPU_ADDR_WIDTH_DFLT-1:0] cpu_addr_t;
    typedef logic [LAR_DATA_WIDTH_DFLT-1:0] lar_data_t;

    typedef enum logic {
        StIdle = 1'b0,
        StXfer = 1'b1
    } state_t;

    typedef logic [$clog2(NUM_BEATS_DFLT)-1:0] beat_idx_t;

    typedef struct packed {
        logic                       req;
        logic                       we;
        cpu_addr_t                  addr;
        logic [BEAT_WIDTH_DFLT-1:0] wdata;
    } partial_port_out_ext_mem_t;

    typedef struct packed {
        logic                       ack;
        logic [BEAT_WIDTH_DFLT-1:0] rdata;
    } partial_port_in_ext_mem_t;

endpackage

// File: rtl/snow64_ext_mem_bridge.sv
// Serializes one wide CPU line transfer into NUM_BEATS narrow req/ack beats,
// assembling read beats back into a registered line for the CPU.
module snow64_ext_mem_bridge
    import snow64_ext_mem_bridge_pkg::*;
#(
    parameter int LAR_DATA_WIDTH = LAR_DATA_WIDTH_DFLT,
    parameter int CPU_ADDR_WIDTH = CPU_ADDR_WIDTH_DFLT,
    parameter int BEAT_WIDTH     = BEAT_WIDTH_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_cpu_req,
    input  logic                      in_cpu_access_type,
    input  logic [CPU_ADDR_WIDTH-1:0] in_cpu_addr,
    input  logic [LAR_DATA_WIDTH-1:0] in_cpu_data,
    output logic                      out_cpu_busy,
    output logic [LAR_DATA_WIDTH-1:0] out_cpu_data,
    output logic                      out_mem_req,
    output logic                      out_mem_we,
    output logic [CPU_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [BEAT_WIDTH-1:0]     out_mem_wdata,
    input  logic                      in_mem_ack,
    input  logic [BEAT_WIDTH-1:0]     in_mem_rdata
);

    localparam int NUM_BEATS  = LAR_DATA_WIDTH / BEAT_WIDTH;
    localparam int BEAT_IDX_W = $clog2(NUM_BEATS);
    localparam int BYTE_BITS  = $clog2(BEAT_WIDTH / 8);
    localparam int LINE_OFF   = BEAT_IDX_W + BYTE_BITS;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);

    state_t                      state_q, state_d;
    logic [BEAT_IDX_W-1:0]       beat_q, beat_d;
    logic [BEAT_IDX_W-1:0]       beat_nxt;
    logic [LAR_DATA_WIDTH-1:0]   line_q, line_d;
    logic [LAR_DATA_WIDTH-1:0]   cpu_data_q, cpu_data_d;
    logic                        busy_q, busy_d;
    logic                        mem_req_q, mem_req_d;
    logic                        mem_we_q, mem_we_d;
    logic [CPU_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic                        unused_addr_lsbs;

    // The line offset is discarded; transfers are always whole aligned lines.
    assign unused_addr_lsbs = ^in_cpu_addr[LINE_OFF-1:0];

    function automatic logic [CPU_ADDR_WIDTH-1:0] beat_addr(
        input logic [CPU_ADDR_WIDTH-LINE_OFF-1:0] line_addr,
        input logic [BEAT_IDX_W-1:0]              idx
    );
        return {line_addr, idx, {BYTE_BITS{1'b0}}};
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] beat_slice(
        input logic [LAR_DATA_WIDTH-1:0] line,
        input logic [BEAT_IDX_W-1:0]     idx
    );
        return line[idx*BEAT_WIDTH +: BEAT_WIDTH];
    endfunction

    assign beat_nxt = beat_q + 1'b1;

    // Next-state and next-output computation; bus outputs are registered one beat ahead.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        cpu_data_d  = cpu_data_q;
        busy_d      = busy_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (in_cpu_req) begin
                    state_d     = StXfer;
                    beat_d      = '0;
                    line_d      = in_cpu_data;
                    busy_d      = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = in_cpu_access_type;
                    mem_addr_d  = beat_addr(in_cpu_addr[CPU_ADDR_WIDTH-1:LINE_OFF], '0);
                    mem_wdata_d = beat_slice(in_cpu_data, '0);
                end else begin
                    state_d = StIdle;
                end
            end
            StXfer: begin
                if (in_mem_ack) begin
                    if (!mem_we_q) begin
                        cpu_data_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = in_mem_rdata;
                    end else begin
                        cpu_data_d = cpu_data_q;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d     = StIdle;
                        busy_d      = 1'b0;
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = beat_addr(mem_addr_q[CPU_ADDR_WIDTH-1:LINE_OFF], beat_nxt);
                        mem_wdata_d = beat_slice(line_q, beat_nxt);
                    end
                end else begin
                    state_d = StXfer;
                end
            end
            default: begin
                state_d     = StIdle;
                beat_d      = '0;
                busy_d      = 1'b0;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            line_q      <= '0;
            cpu_data_q  <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            cpu_data_q  <= cpu_data_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign out_cpu_busy  = busy_q;
    assign out_cpu_data  = cpu_data_q;
    assign out_mem_req   = mem_req_q;
    assign out_mem_we    = mem_we_q;
    assign out_mem_addr  = mem_addr_q;
    assign out_mem_wdata = mem_wdata_q;

endmodule
